serial_tx_frame_controller: RTL
===============================

// Module: serial_tx_frame_controller
// PURPOSE
// - Frame sequencer for the serial send datapath. Accepts one parallel word per valid/ready handshake.
// - Emits a serial frame on tx_out, each bit held for BAUD_DIV clocks: start bit, LENGTH data bits MSB first, optional parity bit, stop bit.
// - Drives bit_index and shift_enable so an attached PISO register stays in lock-step.
// - Reports completion to the upstream sender.
// PARAMETERS
// - LENGTH    default 8   data bits per frame; legal 1..16
// - BAUD_DIV  default 16  clocks per serial bit; legal 1..65535
// - DIV_W     default 16  width of the baud counter; must satisfy 2**DIV_W >= BAUD_DIV
// PORTS
// - clk           in   1       rising-edge clock
// - reset         in   1       asynchronous, active-high reset
// - data_in       in   LENGTH  parallel word; sampled only on accept
// - data_valid    in   1       upstream has a word
// - data_ready    out  1       controller can accept; 1 only in IDLE
// - tx_out        out  1       serial line; idles high
// - busy          out  1       1 in every state except IDLE
// - shift_enable  out  1       1-cycle strobe on the last clock of each data bit
// - bit_index     out  4       index of the data bit on tx_out; counts LENGTH-1 down to 0
// - frame_done    out  1       1-cycle pulse on the last clock of the stop bit
// BEHAVIOUR
// - Reset values: state=IDLE, tx_out=1, data_ready=1, busy=0, shift_enable=0, frame_done=0, bit_index=LENGTH-1, baud counter=BAUD_DIV-1, holding register=0.
// - Accept: data_valid && data_ready at a rising edge.
//   - At that edge: latch data_in, move to START, load baud counter with BAUD_DIV-1.
//   - data_valid outside IDLE is ignored; the word is not consumed.
// - Outputs are decoded from registered state only (no combinational path from inputs).
// - tx_out by state: IDLE=1, START=0, DATA=hold[bit_index], PARITY=^hold (even parity), STOP=1.
// - Baud counter: decrements every clock while busy. On reaching 0, reload BAUD_DIV-1 and advance state.
//   - Every bit lasts exactly BAUD_DIV clocks.
//   - BAUD_DIV=1: counter stays 0; state advances every clock.
// - Transitions:
//   - IDLE -> START on accept.
//   - START -> DATA at count 0.
//   - DATA: at count 0, if bit_index != 0 then decrement bit_index and stay in DATA.
//   - DATA at count 0 with bit_index == 0 -> PARITY (macro defined) or STOP (macro undefined); bit_index reloads LENGTH-1.
//   - PARITY -> STOP at count 0.
//   - STOP -> IDLE at count 0.
// - shift_enable = (state==DATA) && (count==0).
// - frame_done = (state==STOP) && (count==0).
// - Frame timing:
//   - Frame occupies (LENGTH+2[+1 with parity])*BAUD_DIV clocks after the accept edge.
//   - data_ready rises on the clock after frame_done.
//   - Back-to-back words therefore have exactly one idle-high clock between the stop bit and the next start bit.
// - Reset mid-frame: immediate return to reset values; the frame is truncated; the word is lost and not reported via frame_done.
// - Holding register is stable for the whole frame; data_in changes after accept have no effect.
// CONFIGURATION
// - Macro SERIAL_TX_PARITY_EN.
// - Defined: PARITY state inserted between DATA and STOP, carrying even parity of the latched word. Frame = LENGTH+3 bits.
// - Undefined: PARITY state and its logic absent. DATA goes directly to STOP. Frame = LENGTH+2 bits.
// TESTING
// - LENGTH=8, BAUD_DIV=4, no parity, send 0xA5.
//   - tx_out over 40 clocks after accept, 4 clocks per bit: 0,1,0,1,0,0,1,0,1,1.
//   - frame_done pulses at clock 40; data_ready=1 at clock 41.
// - Same config, send 0xA5 with SERIAL_TX_PARITY_EN defined.
//   - Parity bit=0; frame is 44 clocks; stop bit occupies clocks 41-44.
//   - Send 0x01: parity bit=1.
// - data_valid held high for 3 words 0x00, 0xFF, 0x3C.
//   - Three accepts, each 1 clock after the previous frame_done.
//   - data_in toggled mid-frame does not alter tx_out.
// - Assert reset at clock 15 of a frame.
//   - Same clock: tx_out=1, busy=0, data_ready=1.
//   - No frame_done; the next frame after reset release is correct.
// - BAUD_DIV=1, LENGTH=1, send 1.
//   - tx_out = 0,1,1 on consecutive clocks.
//   - shift_enable high for exactly 1 clock; frame_done at clock 3.
// - Count shift_enable pulses per frame: exactly LENGTH.
//   - bit_index sequence 7..0, each value held BAUD_DIV clocks.

Source files
------------

// File: rtl/serial_tx_frame_controller.sv
// Serial frame sequencer: start bit, LENGTH data bits MSB first, optional even parity, stop bit.
// Optional parity stage is enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx_frame_controller #(
  parameter int unsigned LENGTH   = 8,
  parameter int unsigned BAUD_DIV = 16,
  parameter int unsigned DIV_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LENGTH-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              shift_enable,
  output logic [3:0]        bit_index,
  output logic              frame_done
);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;
`endif

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(BAUD_DIV - 1);
  localparam logic [3:0]       LAST_IDX   = 4'(LENGTH - 1);

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          idx_q, idx_d;
  logic [LENGTH-1:0]   hold_q, hold_d;
  logic [15:0]         hold_ext;
  logic                cnt_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= DIV_RELOAD;
      idx_q   <= LAST_IDX;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  assign cnt_zero = (cnt_q == '0);
  // Zero-extended copy lets bit_index select a bit without out-of-range indexing when LENGTH < 16.
  assign hold_ext = 16'(hold_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    data_ready   = 1'b0;
    busy         = 1'b1;
    tx_out       = 1'b1;
    shift_enable = 1'b0;
    frame_done   = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = cnt_zero ? DIV_RELOAD : (cnt_q - DIV_W'(1));
    end

    case (state_q)
      ST_IDLE: begin
        data_ready = 1'b1;
        busy       = 1'b0;
        tx_out     = 1'b1;
        if (data_valid) begin
          state_d = ST_START;
          cnt_d   = DIV_RELOAD;
          hold_d  = data_in;
        end
      end
      ST_START: begin
        tx_out = 1'b0;
        if (cnt_zero) state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_out       = hold_ext[idx_q];
        shift_enable = cnt_zero;
        if (cnt_zero) begin
          if (idx_q != 4'd0) begin
            idx_d = idx_q - 4'd1;
          end else begin
            idx_d = LAST_IDX;
`ifdef SERIAL_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        tx_out = ^hold_q;
        if (cnt_zero) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        tx_out     = 1'b1;
        frame_done = cnt_zero;
        if (cnt_zero) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bit_index = idx_q;

endmodule
